// File: rtl/pipeline_pkg.sv
// Shared types and widths for the pipeline hazard controller and its helpers.
package pipeline_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  function automatic logic src_match(input logic use_src,
                                     input logic [REG_ADDR_W-1:0] rs,
                                     input logic [REG_ADDR_W-1:0] rd);
    return use_src && (rs == rd);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive data-memory wait cycles and raises a sticky error once the
// count reaches MEM_TIMEOUT; only reset clears the error.
module mem_watchdog
  import pipeline_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_wait,
  output logic mem_err
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT);

  logic [CntW-1:0] cnt_q;
  logic            mem_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      if (!in_wait) begin
        cnt_q <= '0;
      end else if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // Error lands on the same edge the count reaches MEM_TIMEOUT.
      if (in_wait && (cnt_q == CntMax - 1'b1)) begin
        mem_err_q <= 1'b1;
      end
    end
  end

  assign mem_err = mem_err_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage core: load-use, taken-branch and memory-wait
// handling. Optional performance counters are enabled with `PIPE_PERF_EN.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_ruwr,
  input  logic                  ex_branch_taken,
  input  logic                  mem_dm_req,
  input  logic                  mem_dm_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  memwb_bubble,
  output logic [1:0]            state,
  output logic                  mem_err
`ifdef PIPE_PERF_EN
  ,
  output logic [XLEN-1:0]       perf_stall_cycles,
  output logic [XLEN-1:0]       perf_flush_count
`endif
);

  hz_state_t state_q;
  logic      lu_raw;
  logic      lu;
  logic      mw;

  assign lu_raw = ex_is_load && ex_ruwr && (ex_rd != '0) &&
                  (src_match(id_use_rs1, id_rs1, ex_rd) ||
                   src_match(id_use_rs2, id_rs2, ex_rd));
  // The stalled instruction is still in ID during LU_STALL; don't stall it twice.
  assign lu = lu_raw && (state_q != LU_STALL);
  assign mw = mem_dm_req && !mem_dm_ready;

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b0;
    if (!rst_n) begin
      // Clock bubbles into every stage while the PC is held at its reset value.
      pc_en        = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_flush  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (mw) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mw) begin
            state_q <= MEM_WAIT;
          end else if (!ex_branch_taken && lu) begin
            state_q <= LU_STALL;
          end
        end
        LU_STALL: state_q <= RUN;
        MEM_WAIT: begin
          if (mem_dm_ready) begin
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign state = state_q;

  mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_wait(state_q == MEM_WAIT),
    .mem_err(mem_err)
  );

`ifdef PIPE_PERF_EN
  logic [XLEN-1:0] stall_cnt_q;
  logic [XLEN-1:0] flush_cnt_q;
  logic            branch_flush;

  assign branch_flush = !mw && ex_branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (branch_flush) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_flush_count  = flush_cnt_q;
`endif

endmodule
